aes_round_ctrl: RTL and testbench

- Iterative AES-128 round sequencer. Accepts one plaintext/key pair per transaction, then drives the round-key-add datapath stage through rounds 0..NR.
- Between rounds it requests each round key from the key-schedule unit and feeds every round result back as the next round's input.
- Presents the final block on a valid/ready output port with backpressure.
- Single owner of the round counter; sits between the top-level I/O wrapper and the round datapath / key schedule.

---
 rtl/aes_round_ctrl.sv | 154 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: walks the round-key-add datapath through rounds 0..NR,
// fetching each later round key from the key schedule and returning the final block on a valid/ready port.
module aes_round_ctrl #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         ksch_req,
    output logic [3:0]   ksch_round,
    input  logic         ksch_ack,
    output logic         rnd_start,
    output logic [3:0]   rnd_round,
    output logic [127:0] rnd_data,
    output logic [127:0] rnd_key,
    input  logic         rnd_ready,
    input  logic         rnd_done,
    input  logic [127:0] rnd_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_ADD_WAIT,
        S_KEY,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] block_q, block_d;
    logic [127:0] key_q, key_d;
    logic [127:0] out_data_q, out_data_d;
    logic [7:0]   tmo_q, tmo_d;
    logic         err_q, err_d;
    logic         rnd_start_q, ksch_req_q, out_valid_q, busy_q;

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        block_d    = block_q;
        key_d      = key_q;
        out_data_d = out_data_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    block_d = in_data;
                    key_d   = in_key;
                    round_d = 4'd0;
                    err_d   = 1'b0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                tmo_d   = 8'd0;
                state_d = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (rnd_ready) begin
                    // The datapath's final-round flag must agree with our own round count.
                    if (rnd_done != (round_q == LAST_ROUND)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (round_q == LAST_ROUND) begin
                        out_data_d = rnd_result;
                        state_d    = S_DONE;
                    end else begin
                        block_d = rnd_result;
                        round_d = round_q + 4'd1;
                        state_d = S_KEY;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_KEY: begin
                if (ksch_ack) begin
                    tmo_d   = 8'd0;
                    state_d = S_ADD;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            round_q     <= 4'd0;
            block_q     <= '0;
            key_q       <= '0;
            out_data_q  <= '0;
            tmo_q       <= 8'd0;
            err_q       <= 1'b0;
            rnd_start_q <= 1'b0;
            ksch_req_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            block_q     <= block_d;
            key_q       <= key_d;
            out_data_q  <= out_data_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            rnd_start_q <= (state_d == S_ADD);
            ksch_req_q  <= (state_d == S_KEY);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign in_ready   = rst && (state_q == S_IDLE);
    assign ksch_req   = ksch_req_q;
    assign ksch_round = round_q;
    assign rnd_start  = rnd_start_q;
    assign rnd_round  = round_q;
    assign rnd_data   = block_q;
    assign rnd_key    = key_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES round datapath and key schedule attached,
// expected ciphertexts queued at issue time and checked by an independent output monitor.
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         ksch_req;
    logic [3:0]   ksch_round;
    logic         ksch_ack;
    logic         rnd_start;
    logic [3:0]   rnd_round;
    logic [127:0] rnd_data;
    logic [127:0] rnd_key;
    logic         rnd_ready = 1'b0;
    logic         rnd_done = 1'b0;
    logic [127:0] rnd_result = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;
    logic         err;

    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int ack_delay = 0;
    int ack_cnt = 0;
    int stub_mode = 0;
    logic [127:0] ks_key = '0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .ksch_req(ksch_req), .ksch_round(ksch_round), .ksch_ack(ksch_ack),
        .rnd_start(rnd_start), .rnd_round(rnd_round), .rnd_data(rnd_data), .rnd_key(rnd_key),
        .rnd_ready(rnd_ready), .rnd_done(rnd_done), .rnd_result(rnd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w[44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] d, input logic [127:0] k, input int r);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        if (r == 0) return d ^ k;
        for (int i = 0; i < 16; i++) s[i] = sbox(d[127-8*i -: 8]);
        for (int row = 0; row < 4; row++)
            for (int c = 0; c < 4; c++)
                t[row+4*c] = s[row+4*((c+row)%4)];
        if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    // ---------------- key schedule and datapath models ----------------
    assign ksch_ack = ksch_req && (ack_cnt >= ack_delay);

    always @(posedge clk) begin
        if (ksch_req && !ksch_ack) ack_cnt <= ack_cnt + 1;
        else ack_cnt <= 0;
        if (ksch_req && ksch_ack) ks_key <= round_key(rnd_key, int'(ksch_round));
    end

    // stub_mode 1: no result for round 3; stub_mode 2: bogus final flag in round 4.
    always @(posedge clk) begin
        rnd_ready <= 1'b0;
        rnd_done  <= 1'b0;
        if (rnd_start && !(stub_mode == 1 && rnd_round == 4'd3)) begin
            rnd_ready  <= 1'b1;
            rnd_done   <= (rnd_round == 4'd10) || (stub_mode == 2 && rnd_round == 4'd4);
            rnd_result <= aes_round(rnd_data, (rnd_round == 4'd0) ? rnd_key : ks_key, int'(rnd_round));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (in_valid && in_ready) start_cnt = 0;
            if (rnd_start) begin
                chk("rnd_round_order", 128'(rnd_round), 128'(start_cnt));
                start_cnt++;
            end
            if (ksch_req) chk("ksch_round", 128'(ksch_round), 128'(start_cnt));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got %h expected no output", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic accept(input logic [127:0] d, input logic [127:0] k);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_accept", 128'(in_ready), 128'(1));
        in_data  = d;
        in_key   = k;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_err(output int n, output logic saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (!err && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) saw_valid = 1'b1;
        end
    endtask

    task automatic check_idle_next(input string name);
        @(posedge clk); #1;
        chk(name, 128'({out_valid, in_ready, busy}), 128'(3'b010));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic sv;

        // Reset state
        #1;
        chk("reset_ctrl", 128'({in_ready, busy, err, rnd_start, ksch_req, out_valid}), 128'(0));
        chk("reset_out_data", out_data, 128'(0));
        #22 rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset", 128'({in_ready, busy, err}), 128'(3'b100));

        // Standard vector, immediate ack
        exp_q.push_back(C1);
        accept(P1, K1);
        wait_out(n);
        chk("latency_std", 128'(n), 128'(32));
        check_idle_next("idle_after_std");
        chk("start_count", 128'(start_cnt), 128'(11));

        // Key schedule ack delayed 5 cycles each round
        ack_delay = 5;
        exp_q.push_back(C2);
        accept(P2, K2);
        wait_out(n);
        chk("latency_ack_delay", 128'(n), 128'(82));
        check_idle_next("idle_after_delay");
        ack_delay = 0;

        // Backpressure in DONE for 20 cycles
        out_ready = 1'b0;
        exp_q.push_back(C1);
        accept(P1, K1);
        wait_out(n);
        chk("latency_bp", 128'(n), 128'(32));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== C1) bad++;
        end
        chk("bp_hold_bad_cycles", 128'(bad), 128'(0));
        out_ready = 1'b1;
        check_idle_next("idle_after_bp");

        // Datapath never answers in round 3: ADD_WAIT for round 3 entered 10 cycles after accept
        stub_mode = 1;
        accept(P1, K1);
        wait_err(n, sv);
        chk("timeout_latency", 128'(n), 128'(10 + 255));
        chk("timeout_no_valid", 128'(sv), 128'(0));
        chk("timeout_idle", 128'({busy, in_ready, out_valid}), 128'(3'b010));
        stub_mode = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("err_sticky", 128'(err), 128'(1));
        exp_q.push_back(C2);
        accept(P2, K2);
        chk("err_cleared", 128'(err), 128'(0));
        wait_out(n);
        chk("latency_after_tmo", 128'(n), 128'(32));
        check_idle_next("idle_after_tmo");

        // Premature final flag in round 4: result arrives 14 cycles after accept
        stub_mode = 2;
        accept(P1, K1);
        wait_err(n, sv);
        chk("done_abort_latency", 128'(n), 128'(14));
        chk("done_abort_no_valid", 128'(sv), 128'(0));
        chk("done_abort_idle", 128'({busy, in_ready}), 128'(2'b01));
        stub_mode = 0;

        // Asynchronous reset during round 6
        accept(P1, K1);
        n = 0;
        while (!(rnd_start && rnd_round == 4'd6) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_round6", 128'(rnd_round), 128'(6));
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ctrl", 128'({in_ready, busy, err, rnd_start, ksch_req, out_valid}), 128'(0));
        chk("async_rst_data", out_data | rnd_data | rnd_key | 128'(rnd_round), 128'(0));
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("in_ready_after_rst", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        exp_q.push_back(C2);
        accept(P2, K2);
        wait_out(n);
        chk("latency_after_rst", 128'(n), 128'(32));
        check_idle_next("idle_after_rst");

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
